// File: rtl/gpio_config_shift_loader.sv
// gpio_config_shift_loader
//
// Per-pad GPIO configuration register with a serial shift stage.
// On the first clock edge after reset it captures the mask-programmed
// default word into the live configuration. After that, housekeeping can
// shift a new word in serially, MSB first, and commit it with a load
// strobe. Stages chain pad to pad through serial_data_out.
//
// Ports:
//   clock            system clock, rising edge
//   resetn           asynchronous active-low reset
//   gpio_defaults    static default configuration word
//   serial_data_in   serial configuration bit, sampled on shift_en
//   shift_en         one-cycle strobe: shift one bit in
//   load             one-cycle strobe: commit the shifted word
//   reload_defaults  one-cycle strobe: restore gpio_defaults
//   serial_data_out  daisy-chain output, MSB of the shift register
//   config_word      live configuration
//   config_valid     high once the defaults have been captured
//   mgmt_ena, oeb_ovr, inp_ena, pullup_ena, pulldown_ena
//                    decoded bits 0..4 of config_word
//   busy             high while a partial word is being shifted
//   load_ok          one-cycle pulse after a committed load
//   load_err         one-cycle pulse after a rejected load

module gpio_config_shift_loader #(
    parameter int CFG_WIDTH = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [CFG_WIDTH-1:0] gpio_defaults,
    input  logic                 serial_data_in,
    input  logic                 shift_en,
    input  logic                 load,
    input  logic                 reload_defaults,
    output logic                 serial_data_out,
    output logic [CFG_WIDTH-1:0] config_word,
    output logic                 config_valid,
    output logic                 mgmt_ena,
    output logic                 oeb_ovr,
    output logic                 inp_ena,
    output logic                 pullup_ena,
    output logic                 pulldown_ena,
    output logic                 busy,
    output logic                 load_ok,
    output logic                 load_err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CFG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                 state;
    state_t                 state_next;
    logic [CFG_WIDTH-1:0]   shreg;
    logic [CNT_WIDTH-1:0]   shift_count;

    logic                   active;
    logic                   do_reload;
    logic                   do_load;
    logic                   do_shift;

    // Strobes are resolved to a single winning action per cycle so a
    // lower-priority strobe can never have a partial effect.
    always_comb begin
        active    = (state != ST_INIT);
        do_reload = active && reload_defaults;
        do_load   = active && !reload_defaults && load;
        do_shift  = active && !reload_defaults && !load && shift_en;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (do_shift) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (do_reload || do_load) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // The shift register is deliberately left untouched by a load, committed
    // or rejected, so a chain of stages keeps its contents intact.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shreg        <= '0;
            shift_count  <= '0;
            config_word  <= '0;
            config_valid <= 1'b0;
            load_ok      <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            if (state == ST_INIT) begin
                config_word  <= gpio_defaults;
                config_valid <= 1'b1;
            end else if (do_reload) begin
                config_word <= gpio_defaults;
                shreg       <= '0;
                shift_count <= '0;
            end else if (do_load) begin
                if (shift_count == CNT_FULL) begin
                    config_word <= shreg;
                    load_ok     <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
                shift_count <= '0;
            end else if (do_shift) begin
                shreg <= {shreg[CFG_WIDTH-2:0], serial_data_in};
                // Saturate so an over-long word can never alias back to a
                // count that looks complete.
                if (shift_count != CNT_MAX) begin
                    shift_count <= shift_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign serial_data_out = shreg[CFG_WIDTH-1];
    assign busy            = (shift_count != '0);
    assign mgmt_ena        = config_word[0];
    assign oeb_ovr         = config_word[1];
    assign inp_ena         = config_word[2];
    assign pullup_ena      = config_word[3];
    assign pulldown_ena    = config_word[4];

endmodule

// File: tb/tb_gpio_config_shift_loader.sv
// Testbench for gpio_config_shift_loader.
// Two stages are instantiated: dut (near, driven by the bench) and u_far,
// whose serial input is the near stage's serial_data_out. Expected values
// come from a rule-level model of each stage (integers for the words,
// a saturating bit count) updated once per clock.

module tb_gpio_config_shift_loader;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] defaults_near = 10'h007;
    logic [9:0] defaults_far  = 10'h155;

    logic serial_data_in = 1'b0;
    logic shift_en = 1'b0;
    logic load = 1'b0;
    logic reload_defaults = 1'b0;
    logic far_shift_en = 1'b0;
    logic far_load = 1'b0;
    logic far_reload = 1'b0;

    logic       n_sdo, n_valid, n_mgmt, n_oeb, n_inp, n_pu, n_pd, n_busy, n_ok, n_err;
    logic [9:0] n_cfg;
    logic       f_sdo, f_valid, f_mgmt, f_oeb, f_inp, f_pu, f_pd, f_busy, f_ok, f_err;
    logic [9:0] f_cfg;

    int checks = 0;
    int failures = 0;

    // rule-level model state, index 0 = near, 1 = far
    int m_cfg[2];
    int m_sh[2];
    int m_cnt[2];
    bit m_valid[2];
    bit m_ok[2];
    bit m_err[2];
    bit m_init[2];

    always #5 clock = ~clock;

    gpio_config_shift_loader dut (
        .clock(clock), .resetn(resetn), .gpio_defaults(defaults_near),
        .serial_data_in(serial_data_in), .shift_en(shift_en), .load(load),
        .reload_defaults(reload_defaults), .serial_data_out(n_sdo),
        .config_word(n_cfg), .config_valid(n_valid), .mgmt_ena(n_mgmt),
        .oeb_ovr(n_oeb), .inp_ena(n_inp), .pullup_ena(n_pu),
        .pulldown_ena(n_pd), .busy(n_busy), .load_ok(n_ok), .load_err(n_err)
    );

    gpio_config_shift_loader u_far (
        .clock(clock), .resetn(resetn), .gpio_defaults(defaults_far),
        .serial_data_in(n_sdo), .shift_en(far_shift_en), .load(far_load),
        .reload_defaults(far_reload), .serial_data_out(f_sdo),
        .config_word(f_cfg), .config_valid(f_valid), .mgmt_ena(f_mgmt),
        .oeb_ovr(f_oeb), .inp_ena(f_inp), .pullup_ena(f_pu),
        .pulldown_ena(f_pd), .busy(f_busy), .load_ok(f_ok), .load_err(f_err)
    );

    logic [19:0] near_obs, far_obs;
    assign near_obs = {n_sdo, n_cfg, n_valid, n_mgmt, n_oeb, n_inp, n_pu, n_pd, n_busy, n_ok, n_err};
    assign far_obs  = {f_sdo, f_cfg, f_valid, f_mgmt, f_oeb, f_inp, f_pu, f_pd, f_busy, f_ok, f_err};

    function automatic logic [19:0] exp_vec(int i);
        logic [9:0] c;
        logic [9:0] s;
        c = m_cfg[i][9:0];
        s = m_sh[i][9:0];
        return {s[9], c, m_valid[i], c[0], c[1], c[2], c[3], c[4],
                (m_cnt[i] != 0), m_ok[i], m_err[i]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cfg[i] = 0; m_sh[i] = 0; m_cnt[i] = 0;
            m_valid[i] = 0; m_ok[i] = 0; m_err[i] = 0; m_init[i] = 1;
        end
    endfunction

    function automatic void model_stage(int i, bit sh, bit ld, bit rl, bit b, int def);
        m_ok[i] = 0;
        m_err[i] = 0;
        if (m_init[i]) begin
            m_cfg[i] = def; m_valid[i] = 1; m_init[i] = 0;
        end else if (rl) begin
            m_cfg[i] = def; m_sh[i] = 0; m_cnt[i] = 0;
        end else if (ld) begin
            if (m_cnt[i] == 10) begin
                m_cfg[i] = m_sh[i]; m_ok[i] = 1;
            end else begin
                m_err[i] = 1;
            end
            m_cnt[i] = 0;
        end else if (sh) begin
            m_sh[i] = (m_sh[i] * 2 + int'(b)) % 1024;
            if (m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
        end
    endfunction

    // One clock with the given strobes; the model advances alongside.
    task automatic step(input bit sh, input bit ld, input bit rl, input bit b,
                        input bit fsh, input bit fld, input bit frl);
        bit fb;
        shift_en = sh; load = ld; reload_defaults = rl; serial_data_in = b;
        far_shift_en = fsh; far_load = fld; far_reload = frl;
        fb = m_sh[0][9];
        @(posedge clock);
        #1;
        model_stage(0, sh, ld, rl, b, int'(defaults_near));
        model_stage(1, fsh, fld, frl, fb, int'(defaults_far));
        shift_en = 0; load = 0; reload_defaults = 0; serial_data_in = 0;
        far_shift_en = 0; far_load = 0; far_reload = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        #12;
        checks++;
        if (near_obs !== 20'h0) begin
            failures++; $display("[TB] FAIL reset_near got=%h want=%h", near_obs, 20'h0);
        end
        checks++;
        if (far_obs !== 20'h0) begin
            failures++; $display("[TB] FAIL reset_far got=%h want=%h", far_obs, 20'h0);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_defaults();
        // strobes on the capture edge must be ignored
        step(1, 1, 0, 1, 0, 0, 0);
        checks++;
        if (near_obs !== {1'b0, 10'h007, 1'b1, 5'b11100, 3'b000}) begin
            failures++; $display("[TB] FAIL defaults_near got=%h want=%h", near_obs,
                                 {1'b0, 10'h007, 1'b1, 5'b11100, 3'b000});
        end
        checks++;
        if (far_obs !== exp_vec(1)) begin
            failures++; $display("[TB] FAIL defaults_far got=%h want=%h", far_obs, exp_vec(1));
        end
    endtask

    task automatic test_full_load();
        logic [9:0] w;
        w = 10'h2A5;
        for (int k = 9; k >= 0; k--) step(1, 0, 0, w[k], 0, 0, 0);
        checks++;
        if (n_busy !== 1'b1 || n_cfg !== 10'h007) begin
            failures++; $display("[TB] FAIL full_pre busy=%b cfg=%h want busy=1 cfg=007", n_busy, n_cfg);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (n_cfg !== 10'h2A5 || n_ok !== 1'b1 || n_err !== 1'b0 || n_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL full_load cfg=%h ok=%b err=%b busy=%b want 2a5/1/0/0",
                                 n_cfg, n_ok, n_err, n_busy);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (n_ok !== 1'b0 || near_obs !== exp_vec(0)) begin
            failures++; $display("[TB] FAIL full_pulse got=%h want=%h", near_obs, exp_vec(0));
        end
    endtask

    task automatic test_short_long();
        for (int k = 0; k < 9; k++) step(1, 0, 0, 1'($urandom), 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (n_err !== 1'b1 || n_ok !== 1'b0 || n_cfg !== 10'h2A5) begin
            failures++; $display("[TB] FAIL short_word err=%b ok=%b cfg=%h want 1/0/2a5", n_err, n_ok, n_cfg);
        end
        for (int k = 0; k < 12; k++) step(1, 0, 0, 1'($urandom), 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (n_err !== 1'b1 || n_busy !== 1'b0 || n_cfg !== 10'h2A5) begin
            failures++; $display("[TB] FAIL long_word err=%b busy=%b cfg=%h want 1/0/2a5", n_err, n_busy, n_cfg);
        end
        checks++;
        if (near_obs !== exp_vec(0)) begin
            failures++; $display("[TB] FAIL long_model got=%h want=%h", near_obs, exp_vec(0));
        end
    endtask

    task automatic test_priority();
        logic [9:0] w;
        w = 10'h13C;
        for (int k = 9; k >= 0; k--) step(1, 0, 0, w[k], 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        checks++;
        if (n_cfg !== 10'h13C || n_ok !== 1'b1 || n_busy !== 1'b0 || n_sdo !== 1'b0) begin
            failures++; $display("[TB] FAIL prio_load cfg=%h ok=%b busy=%b sdo=%b want 13c/1/0/0",
                                 n_cfg, n_ok, n_busy, n_sdo);
        end
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (n_cfg !== 10'h007 || n_ok !== 1'b0 || n_err !== 1'b0 || n_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL prio_reload cfg=%h ok=%b err=%b busy=%b want 007/0/0/0",
                                 n_cfg, n_ok, n_err, n_busy);
        end
        checks++;
        if (near_obs !== exp_vec(0)) begin
            failures++; $display("[TB] FAIL prio_model got=%h want=%h", near_obs, exp_vec(0));
        end
    endtask

    task automatic test_daisy_chain();
        logic [19:0] stream;
        logic [9:0]  far_seen;
        logic [9:0]  near_seen;
        stream = {10'h3FF, 10'h001};
        step(0, 0, 1, 0, 0, 0, 1);
        for (int k = 19; k >= 0; k--) step(1, 0, 0, stream[k], 1, 0, 0);
        // 20 shifts saturate both counters, so both loads are rejected
        step(0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (n_err !== 1'b1 || f_err !== 1'b1) begin
            failures++; $display("[TB] FAIL chain_overlong near_err=%b far_err=%b want 1/1", n_err, f_err);
        end
        for (int k = 9; k >= 0; k--) begin
            far_seen[k]  = f_sdo;
            near_seen[k] = n_sdo;
            step(1, 0, 0, 0, 1, 0, 0);
        end
        checks++;
        if (far_seen !== 10'h3FF) begin
            failures++; $display("[TB] FAIL chain_far_held got=%h want=%h", far_seen, 10'h3FF);
        end
        checks++;
        if (near_seen !== 10'h001) begin
            failures++; $display("[TB] FAIL chain_near_held got=%h want=%h", near_seen, 10'h001);
        end
        step(0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (f_cfg !== 10'h001 || f_ok !== 1'b1 || n_cfg !== 10'h000 || n_ok !== 1'b1) begin
            failures++; $display("[TB] FAIL chain_commit far=%h/%b near=%h/%b want 001/1 000/1",
                                 f_cfg, f_ok, n_cfg, n_ok);
        end
        checks++;
        if (far_obs !== exp_vec(1)) begin
            failures++; $display("[TB] FAIL chain_far_model got=%h want=%h", far_obs, exp_vec(1));
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0, 0, 0);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (near_obs !== 20'h0) begin
            failures++; $display("[TB] FAIL reset_mid_async got=%h want=%h", near_obs, 20'h0);
        end
        @(posedge clock);
        #1;
        checks++;
        if (near_obs !== 20'h0 || far_obs !== 20'h0) begin
            failures++; $display("[TB] FAIL reset_mid_hold near=%h far=%h want 0", near_obs, far_obs);
        end
        @(negedge clock);
        resetn = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (n_cfg !== 10'h007 || n_busy !== 1'b0 || n_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_mid_recapture cfg=%h busy=%b valid=%b want 007/0/1",
                                 n_cfg, n_busy, n_valid);
        end
    endtask

    task automatic test_random();
        int n;
        for (int burst = 0; burst < 40; burst++) begin
            n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) begin
                step(1, 0, 0, 1'($urandom), 1'($urandom), 0, 0);
                checks++;
                if (near_obs !== exp_vec(0) || far_obs !== exp_vec(1)) begin
                    failures++; $display("[TB] FAIL random_shift near=%h/%h far=%h/%h",
                                         near_obs, exp_vec(0), far_obs, exp_vec(1));
                end
            end
            step(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
            checks++;
            if (near_obs !== exp_vec(0) || far_obs !== exp_vec(1)) begin
                failures++; $display("[TB] FAIL random_strobe near=%h/%h far=%h/%h",
                                     near_obs, exp_vec(0), far_obs, exp_vec(1));
            end
            checks++;
            if ((n_ok && n_err) || (f_ok && f_err)) begin
                failures++; $display("[TB] FAIL random_exclusive near=%b%b far=%b%b want not both",
                                     n_ok, n_err, f_ok, f_err);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_defaults();
        test_full_load();
        test_short_long();
        test_priority();
        test_daisy_chain();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_config_shift_loader.md
Name: gpio_config_shift_loader

Overview:
- Per-pad configuration register and serial shift stage. It is the consumer of the 10-bit mask-programmed GPIO default word.
- After reset it captures the default word into the live configuration register.
- It then accepts serial reconfiguration words from housekeeping. Stages can be daisy-chained pad to pad through serial_data_out.
- The live configuration and its decoded pad-control fields drive the pad control logic.

Parameters:
- CFG_WIDTH, 10, width of the configuration word. The logic is written generically; the only supported value is 10.
- CNT_WIDTH, 4, width of the bit counter. It must hold CFG_WIDTH+1 without overflow.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  reset, asynchronous assert, active-low.
- gpio_defaults  input  10  static default configuration word from the defaults block.
- serial_data_in  input  1  serial config bit, sampled when shift_en=1.
- shift_en  input  1  one-cycle strobe: shift one bit in.
- load  input  1  one-cycle strobe: commit the shifted word.
- reload_defaults  input  1  one-cycle strobe: restore gpio_defaults.
- serial_data_out  output  1  daisy-chain output; equals shreg[9].
- config_word  output  10  live configuration.
- config_valid  output  1  high once defaults have been captured.
- mgmt_ena  output  1  config_word[0].
- oeb_ovr  output  1  config_word[1].
- inp_ena  output  1  config_word[2].
- pullup_ena  output  1  config_word[3].
- pulldown_ena  output  1  config_word[4].
- busy  output  1  high when shift_count != 0.
- load_ok  output  1  one-cycle pulse on a committed load.
- load_err  output  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State=INIT.
  - shreg, config_word, shift_count = 0.
  - config_valid, load_ok, load_err = 0.
  - serial_data_out=0.
- States:
  - INIT: first clock edge after reset release does config_word<=gpio_defaults and config_valid<=1, then goes to IDLE. All strobes are ignored while in INIT.
  - IDLE: shift_count=0. A shift_en goes to SHIFT.
  - SHIFT: accumulating bits. load or reload_defaults returns to IDLE.
- Shift: shreg <= {shreg[8:0], serial_data_in}. Bits arrive MSB first; the word is complete after 10 shifts.
  - shift_count increments and saturates at 15; it never wraps.
  - serial_data_out is shreg[9] as registered before the shift, so the chain delay is 10 shifts per stage.
- Load, in IDLE or SHIFT:
  - If shift_count==10: config_word<=shreg and load_ok pulses the next cycle.
  - Otherwise (0..9 or 11..15): config_word is unchanged and load_err pulses.
  - In both cases shift_count<=0, state<=IDLE, and shreg is retained so the chain stays intact.
- reload_defaults:
  - config_word<=gpio_defaults, shreg<=0, shift_count<=0, state<=IDLE.
  - No load_ok or load_err pulse.
- Priority within one cycle: reload_defaults > load > shift_en. A lower-priority strobe asserted together with a higher one is discarded completely, with no partial effect.
- Decoded outputs are purely combinational from config_word; they add no latency.
- load_ok and load_err are registered, never high together, and high for exactly one cycle.
- gpio_defaults is assumed static. It is sampled only in INIT and on reload_defaults.
- Reset mid-shift: all state clears immediately. The defaults are re-captured in INIT on the first edge after release, and any partial word is lost.

Test Plan:
- Defaults capture:
  - Stimulus: gpio_defaults=10'h007, release reset.
  - Required: on the first edge config_word=10'h007, config_valid=1, mgmt_ena=1, oeb_ovr=1, inp_ena=1, pullup_ena=0, busy=0.
- Full serial load:
  - Stimulus: shift 10'h2A5 MSB first (10 strobes), then load.
  - Required: config_word=10'h2A5 on the following edge, load_ok high for 1 cycle, busy=0.
- Short and long words:
  - Stimulus 1: 9 shifts then load. Required: load_err pulses, config_word unchanged.
  - Stimulus 2: 12 shifts then load. Required: load_err pulses, shift_count returns to 0.
- Daisy-chain:
  - Stimulus: two instances chained out->in; shift {10'h3FF, 10'h001} (20 strobes), then load both.
  - Required: the far stage holds 10'h3FF, the near stage holds 10'h001.
- Priority:
  - Stimulus 1: load+shift_en in the same cycle after 10 shifts. Required: commit of the original word, extra bit discarded.
  - Stimulus 2: reload_defaults+load. Required: config_word=gpio_defaults, no pulse.
- Reset mid-operation:
  - Stimulus: resetn low after 5 shifts, then released.
  - Required: outputs 0 during reset; on the first edge after release config_word=gpio_defaults, busy=0.
